// File: rtl/axi2apb_req_arb_if.sv
// axi2apb_req_arb_if: requester-side and APB-request-side signals of the axi2apb request arbiter
//   master: arbiter view (drives ACK/DATAR/ERROR/GRANT and all M_* requests)
//   slave : environment view (requesters plus downstream APB block)
//   Per-requester fields are packed, requester i at [i*w +: w].
interface axi2apb_req_arb_if #(
  parameter int NUM_REQ    = 2,
  parameter int NUM_PSLAVE = 8,
  parameter int WIDTH_PAD  = 32
);
  logic [NUM_REQ-1:0]           REQ;
  logic [NUM_REQ-1:0]           ACK;
  logic [NUM_REQ*WIDTH_PAD-1:0] ADDR;
  logic [NUM_REQ-1:0]           WR;
  logic [NUM_REQ*32-1:0]        DATAW;
  logic [NUM_REQ*4-1:0]         BE;
  logic [NUM_REQ*3-1:0]         PROT;
  logic [31:0]                  DATAR;
  logic                         ERROR;
  logic [NUM_REQ-1:0]           GRANT;
  logic                         M_REQ;
  logic                         M_ACK;
  logic [NUM_PSLAVE-1:0]        M_SEL;
  logic [WIDTH_PAD-1:0]         M_ADDR;
  logic                         M_WR;
  logic [31:0]                  M_DATAW;
  logic [3:0]                   M_BE;
  logic [2:0]                   M_PROT;
  logic [31:0]                  M_DATAR;
  logic                         M_ERROR;
  modport master (
    input  REQ, ADDR, WR, DATAW, BE, PROT, M_ACK, M_DATAR, M_ERROR,
    output ACK, DATAR, ERROR, GRANT, M_REQ, M_SEL, M_ADDR, M_WR, M_DATAW, M_BE, M_PROT
  );
  modport slave (
    output REQ, ADDR, WR, DATAW, BE, PROT, M_ACK, M_DATAR, M_ERROR,
    input  ACK, DATAR, ERROR, GRANT, M_REQ, M_SEL, M_ADDR, M_WR, M_DATAW, M_BE, M_PROT
  );
endinterface

// File: rtl/axi2apb_req_arb.sv
// axi2apb_req_arb: round-robin arbiter sharing one axi2apb APB request port among NUM_REQ requesters
//   PCLK   : clock
//   PRESET : synchronous active-high reset
//   bus    : axi2apb_req_arb_if.master, its parameters must match this module's
//   Upstream REQ/ACK and downstream M_REQ/M_ACK are four-phase; all outputs are registered.
//   Addresses whose slave index is >= NUM_PSLAVE complete locally with ERROR=1.
module axi2apb_req_arb #(
  parameter int NUM_REQ    = 2,
  parameter int NUM_PSLAVE = 8,
  parameter int WIDTH_PAD  = 32,
  parameter int SEL_LSB    = 12,
  parameter int SEL_W      = 3
) (
  input logic PCLK,
  input logic PRESET,
  axi2apb_req_arb_if.master bus
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] IDLE = 2'd0, MREQ = 2'd1, MREL = 2'd2, UACK = 2'd3;
  logic [1:0] state;
  logic [PW-1:0] ptr, g, pick, j;
  logic [WIDTH_PAD-1:0] a;
  logic [SEL_W-1:0] idx;
  logic in_range;
  // Walk offsets downward so the requester closest above ptr is the last, winning, assignment.
  always_comb begin
    pick = '0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = PW'((int'(ptr) + k) % NUM_REQ);
      if (bus.REQ[j]) pick = j;
    end
  end
  assign a = bus.ADDR[pick*WIDTH_PAD +: WIDTH_PAD];
  assign idx = a[SEL_LSB +: SEL_W];
  assign in_range = int'(idx) < NUM_PSLAVE;
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      bus.ACK <= '0;
      bus.GRANT <= '0;
      bus.DATAR <= '0;
      bus.ERROR <= 1'b0;
      bus.M_REQ <= 1'b0;
      bus.M_SEL <= '0;
      bus.M_ADDR <= '0;
      bus.M_WR <= 1'b0;
      bus.M_DATAW <= '0;
      bus.M_BE <= '0;
      bus.M_PROT <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.REQ) begin
          g <= pick;
          bus.GRANT <= NUM_REQ'(1) << pick;
          bus.M_ADDR <= a;
          bus.M_WR <= bus.WR[pick];
          bus.M_DATAW <= bus.DATAW[pick*32 +: 32];
          bus.M_BE <= bus.BE[pick*4 +: 4] & {4{bus.WR[pick]}};
          bus.M_PROT <= bus.PROT[pick*3 +: 3];
          bus.M_SEL <= in_range ? NUM_PSLAVE'(1) << idx : '0;
          bus.M_REQ <= in_range;
          // Out-of-range: answer immediately, nothing goes downstream.
          if (!in_range) begin
            bus.DATAR <= '0;
            bus.ERROR <= 1'b1;
            bus.ACK <= NUM_REQ'(1) << pick;
          end
          state <= in_range ? MREQ : UACK;
        end
        MREQ: if (bus.M_ACK) begin
          bus.DATAR <= bus.M_DATAR;
          bus.ERROR <= bus.M_ERROR;
          bus.M_REQ <= 1'b0;
          state <= MREL;
        end
        MREL: if (!bus.M_ACK) begin
          bus.ACK <= NUM_REQ'(1) << g;
          state <= UACK;
        end
        default: if (!bus.REQ[g]) begin
          bus.ACK <= '0;
          bus.GRANT <= '0;
          bus.M_SEL <= '0;
          ptr <= (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
